pio_in_irq: RTL and testbench
=============================

Name: pio_in_irq

Overview:
- Parametrised Avalon-MM input PIO with a 2-flop synchroniser, an optional per-bit debounce filter, a per-bit edge-capture register and a maskable interrupt.
- Next generation of the team's simple registered-read input port (button/switch inputs). Sits between board pins and the Nios II data master.
- Adds the standard 4-word register map: data, reserved, irqmask, edgecapture.

Parameters:
- WIDTH, 4: number of input bits (1..32).
- DEBOUNCE_CYCLES, 0: consecutive synchronised cycles a new level must persist before it is accepted. 0 and 1 both mean no filtering.
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge sets edgecapture.
- IRQ_TYPE, 0: 0 = edge (irq from edgecapture), 1 = level (irq from filtered data).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  interrupt request, active-high.

Behaviour:
- Reset (async assert, sync-released by the system): s1, s2, filt, debounce counters, irqmask, edgecapture, readdata and irq all = 0.
- Synchroniser: s1 <= in_port; s2 <= s1.
- Filter, DEBOUNCE_CYCLES <= 1: filt <= s2 every cycle.
- Filter, DEBOUNCE_CYCLES = N >= 2, per bit i:
  - if s2[i] == filt[i]: cnt[i] <= 0.
  - else if cnt[i] == N-1: filt[i] <= s2[i], cnt[i] <= 0.
  - else: cnt[i] <= cnt[i]+1.
  - Counter width is clog2(N). A glitch shorter than N cycles never reaches filt.
- Input latency: in_port change sampled at edge k gives filt updated at edge k+2 (N <= 1) or k+N+1 (N >= 2). readdata shows it one edge later when address = 0.
- Edge detect: computed from (next filt, current filt). edgecapture[i] is set on the same edge filt[i] changes, in the polarity selected by EDGE_TYPE.
- Power-up: filt resets to 0, so an input held high through reset produces a rising edge after release. This is intended.
- Register map, reads (no side effects):
  - 0: filt zero-extended.
  - 1: reads 0.
  - 2: irqmask zero-extended.
  - 3: edgecapture zero-extended.
  - Bits at and above WIDTH read 0.
- readdata: registered every cycle from the address mux, regardless of chipselect. Latency is 1 clock from address to readdata.
- Writes (chipselect=1, write_n=0):
  - 0 and 1: ignored.
  - 2: irqmask <= writedata[WIDTH-1:0].
  - 3: write-1-to-clear, edgecapture[i] cleared where writedata[i]=1.
- Simultaneous clear and new edge on the same bit in the same cycle: set wins, bit stays 1.
- irq: registered.
  - IRQ_TYPE=0: irq <= |(edgecapture_next & irqmask_next).
  - IRQ_TYPE=1: irq <= |(filt_next & irqmask_next).
  - irq therefore asserts on the same edge edgecapture sets when the mask is already enabled, and deasserts on the edge the clear or mask write takes effect.
- Reset mid-operation: all state returns to 0 immediately. Pending edges and partial debounce counts are discarded.

Test Plan:
- WIDTH=4, N=0: in_port 0->4'b0101 at edge k -> filt=5 at k+2. With address=0, readdata=32'h5 at k+3. edgecapture=4'b0101 (EDGE_TYPE=0).
- N=4: 3-cycle pulse on in_port[2] -> filt and edgecapture unchanged. 6-cycle pulse -> filt[2] rises at k+5, falls 6 cycles later, edgecapture[2]=1.
- irqmask=4'b0010, rising edge on bit 1 -> irq=1 on the edgecapture-set edge. Write 32'h2 to address 3 -> edgecapture=0, irq=0 next edge. An edge on bit 0 leaves irq=0.
- Write 1 to clear bit 3 in the same cycle a new rising edge on bit 3 is captured -> edgecapture[3] stays 1 and irq stays 1.
- EDGE_TYPE=2, IRQ_TYPE=1, mask=4'hF: toggle bit 0 -> edgecapture[0] set on both transitions. irq follows filt[0] and stays 1 after the edgecapture clear while the input is high.
- reset_n pulsed low mid-debounce with edgecapture=4'hF and mask=4'hF -> all registers, readdata and irq are 0 immediately. An input held high gives a rising capture N+2 cycles after release.

Source files
------------

// File: rtl/pio_in_irq.sv
// pio_in_irq: Avalon-MM input PIO for button/switch style inputs.
//
// Data path: in_port -> 2-flop synchroniser (s1, s2) -> optional per-bit
// debounce filter (filt) -> edge detector -> edgecapture -> maskable irq.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    Avalon word address (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  write data
//   in_port    asynchronous external inputs (WIDTH bits)
//   readdata   registered read data
//   irq        registered interrupt request, active-high
//
// Bus semantics: Avalon-MM slave with no waitrequest. A write takes effect on
// the clock edge where chipselect=1 and write_n=0. readdata is reloaded every
// cycle from the address mux (chipselect is not needed for reads), so read
// latency is exactly one clock. Reads have no side effects.
module pio_in_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_TYPE        = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic             wr_en;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] clr_mask;

  // Only writedata[WIDTH-1:0] carries register content.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // Synchroniser.
  always_comb begin
    s1_d = in_port;
    s2_d = s1_q;
  end

  // Debounce filter. A bit of filt only changes after s2 has disagreed with
  // it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  generate
    if (DEBOUNCE_CYCLES >= 2) begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_q [WIDTH];
      logic [CW-1:0] cnt_d [WIDTH];

      always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_d[i] = cnt_q[i];
          if (s2_q[i] == filt_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            filt_d[i] = s2_q[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_no_debounce
      always_comb begin
        filt_d = s2_q;
      end
    end
  endgenerate

  // Edge detection compares next filt against current filt so edgecapture
  // sets on the same edge filt changes.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_ev = filt_d & ~filt_q;
      1:       edge_ev = ~filt_d & filt_q;
      default: edge_ev = filt_d ^ filt_q;
    endcase
  end

  // Register writes, edgecapture update, irq and read mux.
  always_comb begin
    wr_en     = chipselect && !write_n;
    irqmask_d = irqmask_q;
    clr_mask  = '0;
    if (wr_en && address == 2'd2) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd3) clr_mask  = writedata[WIDTH-1:0];

    // OR-ing the new events after the clear makes a same-cycle set win.
    edgecap_d = (edgecap_q & ~clr_mask) | edge_ev;

    if (IRQ_TYPE == 0) irq_d = |(edgecap_d & irqmask_d);
    else               irq_d = |(filt_d & irqmask_d);

    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = filt_q;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      filt_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      filt_q     <= filt_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_irq.sv
// tb_pio_in_irq: drives four pio_in_irq instances with different parameter
// sets from one shared bus/input stimulus and compares readdata and irq of
// each against a behavioural model every cycle, plus directed spot values.
//   inst 0: N=0 EDGE=rising  IRQ=edge
//   inst 1: N=4 EDGE=rising  IRQ=edge
//   inst 2: N=2 EDGE=falling IRQ=edge
//   inst 3: N=0 EDGE=any     IRQ=level
module tb_pio_in_irq;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;

  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;

  always #5 clk = ~clk;

  pio_in_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_TYPE(0)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));
  pio_in_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IRQ_TYPE(0)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1));
  pio_in_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(2), .EDGE_TYPE(1), .IRQ_TYPE(0)) u_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));
  pio_in_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IRQ_TYPE(1)) u_d (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd3), .irq(irq3));

  function automatic int p_n(int m);
    case (m) 0: return 0; 1: return 4; 2: return 2; default: return 0; endcase
  endfunction
  function automatic int p_e(int m);
    case (m) 0: return 0; 1: return 0; 2: return 1; default: return 2; endcase
  endfunction
  function automatic int p_i(int m);
    return (m == 3) ? 1 : 0;
  endfunction
  function automatic logic [31:0] dut_rd(int m);
    case (m) 0: return rd0; 1: return rd1; 2: return rd2; default: return rd3; endcase
  endfunction
  function automatic logic dut_irq(int m);
    case (m) 0: return irq0; 1: return irq1; 2: return irq2; default: return irq3; endcase
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Input reaches the filter two samples late; with filtering, a bit of filt
  // flips once the last N delayed samples all show the opposite level.
  logic [3:0]  m_dly1 [4];
  logic [3:0]  m_dly2 [4];
  logic [3:0]  m_hist [4][8];
  int          m_hv   [4];
  logic [3:0]  m_filt [4];
  logic [3:0]  m_mask [4];
  logic [3:0]  m_ec   [4];
  logic        m_irq  [4];
  logic [31:0] m_rd   [4];

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      m_dly1[m] = '0; m_dly2[m] = '0; m_hv[m] = 0;
      for (int j = 0; j < 8; j++) m_hist[m][j] = '0;
      m_filt[m] = '0; m_mask[m] = '0; m_ec[m] = '0;
      m_irq[m] = 1'b0; m_rd[m] = '0;
    end
  endtask

  task automatic model_step(input int m);
    logic [3:0] seen, fnew, ev, mnew, clr, ecnew;
    logic       all_opp, wr;
    int         n;
    n = p_n(m);
    case (address)
      2'd0:    m_rd[m] = {28'd0, m_filt[m]};
      2'd2:    m_rd[m] = {28'd0, m_mask[m]};
      2'd3:    m_rd[m] = {28'd0, m_ec[m]};
      default: m_rd[m] = 32'd0;
    endcase
    seen = m_dly2[m];
    if (n <= 1) begin
      fnew = seen;
    end else begin
      for (int j = 7; j > 0; j--) m_hist[m][j] = m_hist[m][j-1];
      m_hist[m][0] = seen;
      if (m_hv[m] < 8) m_hv[m]++;
      fnew = m_filt[m];
      for (int b = 0; b < 4; b++) begin
        all_opp = (m_hv[m] >= n);
        for (int j = 0; j < n; j++)
          if (m_hist[m][j][b] == m_filt[m][b]) all_opp = 1'b0;
        if (all_opp) fnew[b] = ~m_filt[m][b];
      end
    end
    case (p_e(m))
      0:       ev = fnew & ~m_filt[m];
      1:       ev = ~fnew & m_filt[m];
      default: ev = fnew ^ m_filt[m];
    endcase
    wr    = chipselect && !write_n;
    mnew  = (wr && address == 2'd2) ? writedata[3:0] : m_mask[m];
    clr   = (wr && address == 2'd3) ? writedata[3:0] : 4'd0;
    ecnew = (m_ec[m] & ~clr) | ev;
    m_irq[m]  = (p_i(m) == 0) ? |(ecnew & mnew) : |(fnew & mnew);
    m_filt[m] = fnew;
    m_mask[m] = mnew;
    m_ec[m]   = ecnew;
    m_dly2[m] = m_dly1[m];
    m_dly1[m] = in_port;
  endtask

  task automatic compare_all();
    for (int m = 0; m < 4; m++) begin
      check($sformatf("rd%0d", m), dut_rd(m), m_rd[m]);
      check($sformatf("irq%0d", m), {31'd0, dut_irq(m)}, {31'd0, m_irq[m]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
    chipselect = cs; write_n = wn; address = a; writedata = wd;
  endtask

  // Inputs are set just after a rising edge; the model consumes them and
  // the DUT is sampled 1 time unit after the next rising edge.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      for (int m = 0; m < 4; m++) model_step(m);
      @(posedge clk);
      #1;
      compare_all();
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("%s_rd%0d", tag, m), dut_rd(m), 32'd0);
      check($sformatf("%s_irq%0d", tag, m), {31'd0, dut_irq(m)}, 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    in_port = 4'd0;
    bus(1'b0, 1'b1, 2'd0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // Settle with inputs low, then clear any captures.
    run(8);
    bus(1'b1, 1'b0, 2'd3, 32'hF); run(1);
    bus(1'b0, 1'b1, 2'd0, 32'd0); run(1);

    // Latency: 0 -> 0101 on the unfiltered instance.
    in_port = 4'b0101;
    run(3);
    check("lat_rd_k2", rd0, 32'h0);
    run(1);
    check("lat_rd_k3", rd0, 32'h5);
    bus(1'b0, 1'b1, 2'd3, 32'd0); run(1);
    check("lat_ec", rd0, 32'h5);

    // Glitch rejection on the N=4 instance.
    in_port = 4'b0000; run(10);
    bus(1'b1, 1'b0, 2'd3, 32'hF); run(1);
    bus(1'b0, 1'b1, 2'd3, 32'd0);
    in_port = 4'b0100; run(3);
    in_port = 4'b0000; run(8);
    check("glitch_ec", rd1, 32'h0);
    bus(1'b0, 1'b1, 2'd0, 32'd0); run(1);
    check("glitch_filt", rd1, 32'h0);
    // 6-cycle pulse passes the filter.
    in_port = 4'b0100; run(6);
    in_port = 4'b0000; run(1);
    check("pulse6_filt", rd1, 32'h4);
    run(8);
    check("pulse6_fall", rd1, 32'h0);
    bus(1'b0, 1'b1, 2'd3, 32'd0); run(1);
    check("pulse6_ec", rd1, 32'h4);

    // Mask, clear and irq on the unfiltered edge instance.
    bus(1'b1, 1'b0, 2'd3, 32'hF); run(1);
    bus(1'b1, 1'b0, 2'd2, 32'h2); run(1);
    bus(1'b0, 1'b1, 2'd3, 32'd0);
    in_port = 4'b0010; run(3);
    check("mask_irq_set", {31'd0, irq0}, 32'd1);
    bus(1'b1, 1'b0, 2'd3, 32'h2); run(1);
    check("mask_irq_clr", {31'd0, irq0}, 32'd0);
    bus(1'b0, 1'b1, 2'd3, 32'd0);
    in_port = 4'b0011; run(4);
    check("mask_irq_bit0", {31'd0, irq0}, 32'd0);

    // Same-cycle clear and new edge on bit 3: set wins.
    bus(1'b1, 1'b0, 2'd2, 32'h8); run(1);
    bus(1'b0, 1'b1, 2'd3, 32'd0);
    in_port = 4'b1000; run(4);
    in_port = 4'b0000; run(4);
    in_port = 4'b1000; run(2);
    bus(1'b1, 1'b0, 2'd3, 32'h8); run(1);
    check("setwins_irq", {31'd0, irq0}, 32'd1);
    bus(1'b0, 1'b1, 2'd3, 32'd0); run(1);
    check("setwins_ec3", {31'd0, rd0[3]}, 32'd1);

    // Level irq on the any-edge instance survives an edgecapture clear.
    bus(1'b1, 1'b0, 2'd2, 32'hF); run(1);
    bus(1'b0, 1'b1, 2'd0, 32'd0);
    in_port = 4'b0001; run(4);
    bus(1'b1, 1'b0, 2'd3, 32'hF); run(1);
    bus(1'b0, 1'b1, 2'd3, 32'd0); run(1);
    check("level_irq", {31'd0, irq3}, 32'd1);
    in_port = 4'b0000; run(4);
    check("level_ec_fall", rd3, 32'h1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) in_port = 4'($urandom_range(0, 15));
      bus($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), $urandom);
      run(1);
    end

    // Reset mid-debounce with everything set.
    bus(1'b1, 1'b0, 2'd2, 32'hF); run(1);
    bus(1'b0, 1'b1, 2'd3, 32'd0);
    in_port = 4'b1111; run(5);
    in_port = 4'b0000; run(3);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("midrst");
    in_port = 4'b1111;
    @(posedge clk); #1;
    check_all_zero("midrst_hold");
    reset_n = 1'b1;
    run(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
